// File: rtl/reg_sched_pkg.sv
// Shared types and helpers for the round-robin register load scheduler.
package reg_sched_pkg;

   typedef enum logic [1:0] {IDLE, CLEAR, LOAD, ACK} sched_state_t;

   localparam int DW_DEF = 4;

   // Index width that stays at least one bit even for a single-entry bank.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after rr_ptr wins.
module rr_arbiter #(
   parameter  int NREQ = 4,
   localparam int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   rr_ptr,
   output logic            grant_valid,
   output logic [IW-1:0]   grant_idx
);

   logic [IW-1:0] cand;

   // Scan from the farthest offset down so the nearest hit to rr_ptr is written last.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = IW'((32'(rr_ptr) + 32'(k)) % NREQ);
         if (req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/reg_load_sched.sv
// Shares a bank of load/enable registers among requesters: one write per grant,
// plus a bank-wide clear, with all outputs decoded from registered state.
module reg_load_sched
   import reg_sched_pkg::*;
#(
   parameter  int NREQ = 4,
   parameter  int NREG = 4,
   parameter  int DW   = DW_DEF,
   localparam int AW   = addr_w(NREG),
   localparam int IW   = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               clr,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_data,
   input  logic               clear_all,
   output logic [NREQ-1:0]    ack,
   output logic               addr_err,
   output logic [NREG-1:0]    reg_enable,
   output logic [NREG-1:0]    reg_load,
   output logic [NREG-1:0]    reg_clr,
   output logic [DW-1:0]      reg_loadVal,
   output logic               busy
);

   sched_state_t  state_reg, state_next;
   logic [IW-1:0] rr_ptr_reg;
   logic [IW-1:0] idx_reg;
   logic [AW-1:0] addr_reg;
   logic [DW-1:0] data_reg;

   logic          grant_valid;
   logic [IW-1:0] grant_idx;
   logic [AW-1:0] addr_arr [NREQ];
   logic [DW-1:0] data_arr [NREQ];
   logic [NREG-1:0] addr_hit;
   logic [NREQ-1:0] idx_hit;
   logic          addr_bad;
   logic          grant_take;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign addr_arr[gi] = req_addr[gi*AW +: AW];
         assign data_arr[gi] = req_data[gi*DW +: DW];
         assign idx_hit[gi]  = (idx_reg == IW'(gi));
      end
      // An out-of-range address simply matches no bank entry.
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         assign addr_hit[gi] = (addr_reg == AW'(gi));
      end
   endgenerate

   assign addr_bad   = (32'(addr_reg) >= NREG);
   assign grant_take = (state_reg == IDLE) && !clear_all && grant_valid;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req         (req),
      .rr_ptr      (rr_ptr_reg),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (clear_all) begin
               state_next = CLEAR;
            end else if (grant_valid) begin
               state_next = LOAD;
            end
         end
         CLEAR:   state_next = IDLE;
         LOAD:    state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Winner's address and data are captured at the grant edge; later changes are ignored.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         rr_ptr_reg <= '0;
         idx_reg    <= '0;
         addr_reg   <= '0;
         data_reg   <= '0;
      end else begin
         if (grant_take) begin
            idx_reg  <= grant_idx;
            addr_reg <= addr_arr[grant_idx];
            data_reg <= data_arr[grant_idx];
         end
         if (state_reg == ACK) begin
            rr_ptr_reg <= (32'(idx_reg) == NREQ - 1) ? '0 : idx_reg + IW'(1);
         end
      end
   end

   always_comb begin
      ack         = '0;
      addr_err    = 1'b0;
      reg_enable  = '0;
      reg_load    = '0;
      reg_clr     = '0;
      reg_loadVal = '0;
      busy        = (state_reg != IDLE);
      case (state_reg)
         CLEAR: reg_clr = '1;
         LOAD: begin
            reg_enable  = addr_hit;
            reg_load    = addr_hit;
            reg_loadVal = data_reg;
         end
         ACK: begin
            ack      = idx_hit;
            addr_err = addr_bad;
         end
         default: ;
      endcase
   end

endmodule
